// File: rtl/config_pkg.sv
// Shared types and arithmetic helpers for the ternary mat-vec datapath.
// Q5.3 fixed point values are carried as raw 8-bit signed integers.
package config_pkg;

  localparam int D = 4;

  typedef logic signed [7:0] fixed_point_t;
  typedef logic signed [1:0] ternary_t;
  typedef ternary_t [D-1:0][D-1:0] ternary_matrix_t;
  typedef fixed_point_t [D-1:0] vector_t;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} matvec_state_t;
  typedef logic [$clog2(D)-1:0] col_idx_t;

  localparam fixed_point_t FP_MAX = 8'sh7f;
  localparam fixed_point_t FP_MIN = 8'sh80;

  localparam ternary_t T_ZERO    = 2'b00;
  localparam ternary_t T_POS     = 2'b01;
  localparam ternary_t T_ILLEGAL = 2'b10;
  localparam ternary_t T_NEG     = 2'b11;

  function automatic logic ternary_is_legal(ternary_t w);
    return w != T_ILLEGAL;
  endfunction

  function automatic logic [8:0] wide_sum(fixed_point_t a, fixed_point_t b);
    return {a[7], a} + {b[7], b};
  endfunction

  // The 9-bit sum leaves [-128, 127] exactly when its top two bits differ.
  function automatic logic add_saturates(fixed_point_t a, fixed_point_t b);
    logic [8:0] s;
    s = wide_sum(a, b);
    return s[8] != s[7];
  endfunction

  function automatic fixed_point_t fixed_point_add(fixed_point_t a, fixed_point_t b);
    logic [8:0] s;
    s = wide_sum(a, b);
    if (s[8] != s[7]) return s[8] ? FP_MIN : FP_MAX;
    return fixed_point_t'(s[7:0]);
  endfunction

  // Negating -128 has no 8-bit representation, so it clamps to +127.
  // The illegal code behaves as zero.
  function automatic fixed_point_t ternary_mul(ternary_t w, fixed_point_t x);
    case (w)
      T_POS:   return x;
      T_NEG:   return (x == FP_MIN) ? FP_MAX : -x;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/ternary_mac_lane.sv
// One row accumulator: adds ternary_mul(w, x) each enabled cycle with
// saturation, and keeps a sticky flag recording any clamped step.
module ternary_mac_lane
  import config_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         en_i,
  input  ternary_t     w_i,
  input  fixed_point_t x_i,
  output fixed_point_t acc_o,
  output logic         sat_o
);

  fixed_point_t acc_q, acc_d, prod;
  logic         sat_q, sat_d;

  always_comb begin
    prod  = ternary_mul(w_i, x_i);
    acc_d = acc_q;
    sat_d = sat_q;
    if (clear_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en_i) begin
      acc_d = fixed_point_add(acc_q, prod);
      sat_d = sat_q | add_saturates(acc_q, prod);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/ternary_matvec_seq.sv
// Sequencer for y = W*x: latches one job, walks one column of W per cycle
// across D saturating lanes, then holds y until the consumer takes it.
module ternary_matvec_seq
  import config_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  ternary_matrix_t in_w_i,
  input  vector_t         in_x_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output vector_t         out_y_o,
  output logic [D-1:0]    sat_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam col_idx_t LAST_COL = col_idx_t'(D - 1);

  matvec_state_t   state_q, state_d;
  col_idx_t        col_q, col_d;
  ternary_matrix_t w_q, w_d;
  vector_t         x_q, x_d;
  logic            err_q, err_d;
  logic            accept, col_illegal, lane_clear, lane_en;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      w_q     <= '0;
      x_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      w_q     <= w_d;
      x_q     <= x_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    col_illegal = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (!ternary_is_legal(w_q[i][col_q])) col_illegal = 1'b1;
    end
  end

  // Flush overrides everything, including an accept or output handshake.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    w_d     = w_q;
    x_d     = x_q;
    err_d   = err_q;
    if (flush_i) begin
      state_d = IDLE;
      col_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_d = COMPUTE;
            w_d     = in_w_i;
            x_d     = in_x_i;
            col_d   = '0;
            err_d   = 1'b0;
          end
        end
        COMPUTE: begin
          err_d = err_q | col_illegal;
          col_d = col_q + col_idx_t'(1);
          if (col_q == LAST_COL) state_d = DONE;
        end
        DONE: begin
          if (out_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = rst_ni && (state_q == IDLE) && !flush_i;
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q == COMPUTE) || (state_q == DONE);
    accept      = (state_q == IDLE) && in_valid_i && !flush_i;
    lane_clear  = accept || flush_i;
    lane_en     = (state_q == COMPUTE) && !flush_i;
    err_o       = err_q;
  end

  for (genvar i = 0; i < D; i++) begin : g_lane
    ternary_mac_lane u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (lane_clear),
      .en_i    (lane_en),
      .w_i     (w_q[i][col_q]),
      .x_i     (x_q[col_q]),
      .acc_o   (out_y_o[i]),
      .sat_o   (sat_o[i])
    );
  end

endmodule

// File: tb/tb_ternary_matvec_seq.sv
// Directed self-checking bench for ternary_matvec_seq; expected values are
// hand-computed constants per scenario.
module tb_ternary_matvec_seq;
  import config_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  ternary_matrix_t in_w;
  vector_t         in_x;
  logic            out_valid;
  logic            out_ready;
  vector_t         out_y;
  logic [D-1:0]    sat;
  logic            err;
  logic            busy;

  int total;
  int bad;

  ternary_matvec_seq dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_w_i      (in_w),
    .in_x_i      (in_x),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_y_o     (out_y),
    .sat_o       (sat),
    .err_o       (err),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ternary_matrix_t identity_w();
    ternary_matrix_t m;
    m = '0;
    for (int i = 0; i < D; i++) m[i][i] = T_POS;
    return m;
  endfunction

  function automatic ternary_matrix_t sat_w();
    ternary_matrix_t m;
    m = '0;
    for (int j = 0; j < D; j++) begin
      m[0][j] = T_POS;
      m[1][j] = T_NEG;
    end
    return m;
  endfunction

  // Offers a job, then waits (bounded) for out_valid; lat = -1 on timeout.
  task automatic send_job(input ternary_matrix_t w, input vector_t x, output int lat);
    @(negedge clk);
    in_w = w;
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_y !== '0) begin bad++; $display("[TB] FAIL reset_out_y got=%h want=0", out_y); end
    total++; if ({sat, err, busy} !== '0) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0", {sat, err, busy}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_identity();
    vector_t x, e;
    int lat;
    x = '0; x[0] = 8'sd8; x[1] = 8'sd16; x[2] = -8'sd8; x[3] = 8'sd24;
    e = x;
    out_ready = 1'b1;
    send_job(identity_w(), x, lat);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL identity_latency got=%0d want=4", lat); end
    for (int i = 0; i < D; i++) begin
      total++; if (out_y[i] !== e[i]) begin bad++; $display("[TB] FAIL identity_y%0d got=%0d want=%0d", i, out_y[i], e[i]); end
    end
    total++; if ({sat, err} !== '0) begin bad++; $display("[TB] FAIL identity_flags got=%b want=0", {sat, err}); end
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL identity_return got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_saturation();
    vector_t x;
    int lat;
    for (int i = 0; i < D; i++) x[i] = 8'sd127;
    send_job(sat_w(), x, lat);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL sat_latency got=%0d want=4", lat); end
    total++; if (out_y[0] !== 8'sd127) begin bad++; $display("[TB] FAIL sat_y0 got=%0d want=127", out_y[0]); end
    total++; if (out_y[1] !== -8'sd128) begin bad++; $display("[TB] FAIL sat_y1 got=%0d want=-128", out_y[1]); end
    total++; if (out_y[2] !== 8'sd0 || out_y[3] !== 8'sd0) begin bad++; $display("[TB] FAIL sat_y23 got=%0d,%0d want=0,0", out_y[2], out_y[3]); end
    total++; if (sat !== 4'b0011) begin bad++; $display("[TB] FAIL sat_flags got=%b want=0011", sat); end
    take_output();
  endtask

  task automatic test_backpressure();
    vector_t x;
    int lat;
    x = '0; x[0] = 8'sd1; x[1] = 8'sd2; x[2] = 8'sd3; x[3] = 8'sd4;
    out_ready = 1'b0;
    send_job(identity_w(), x, lat);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=4", lat); end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_y !== x || {sat, err} !== '0) begin
        bad++;
        $display("[TB] FAIL bp_hold cyc=%0d got valid=%b ready=%b busy=%b y=%h flags=%b want 1/0/1 y=%h flags=0",
                 c, out_valid, in_ready, busy, out_y, {sat, err}, x);
      end
      @(negedge clk);
    end
    take_output();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_flush();
    vector_t x, e;
    ternary_matrix_t w;
    int lat;
    logic seen;
    for (int i = 0; i < D; i++) x[i] = 8'sd127;
    @(negedge clk);
    in_w = sat_w();
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready_compute got=%b want=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_idle got busy=%b valid=%b ready=%b want 0/0/0", busy, out_valid, in_ready); end
    total++; if (sat !== '0 || out_y !== '0) begin bad++; $display("[TB] FAIL flush_clear got sat=%b y=%h want 0", sat, out_y); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_accept got busy=%b want=0", busy); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_output got seen=%b want=0", seen); end
    w = '0;
    w[0][0] = T_POS; w[0][1] = T_POS;
    w[1][0] = T_NEG; w[1][2] = T_POS;
    w[2][3] = T_NEG;
    w[3][0] = T_POS; w[3][1] = T_NEG; w[3][2] = T_POS; w[3][3] = T_NEG;
    x[0] = 8'sd10; x[1] = 8'sd20; x[2] = 8'sd30; x[3] = 8'sd40;
    e[0] = 8'sd30; e[1] = 8'sd20; e[2] = -8'sd40; e[3] = -8'sd20;
    send_job(w, x, lat);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL flush_next_latency got=%0d want=4", lat); end
    for (int i = 0; i < D; i++) begin
      total++; if (out_y[i] !== e[i]) begin bad++; $display("[TB] FAIL flush_next_y%0d got=%0d want=%0d", i, out_y[i], e[i]); end
    end
    total++; if ({sat, err} !== '0) begin bad++; $display("[TB] FAIL flush_next_flags got=%b want=0", {sat, err}); end
    take_output();
  endtask

  task automatic test_illegal();
    ternary_matrix_t w;
    vector_t x, e;
    int lat;
    w = '0;
    w[2][1] = T_ILLEGAL;
    w[2][0] = T_POS;
    for (int i = 0; i < D; i++) x[i] = 8'sd8;
    e = '0; e[2] = 8'sd8;
    send_job(w, x, lat);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL illegal_latency got=%0d want=4", lat); end
    total++; if (out_y !== e) begin bad++; $display("[TB] FAIL illegal_y got=%h want=%h", out_y, e); end
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL illegal_err got=%b want=1", err); end
    take_output();
    send_job(identity_w(), x, lat);
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL illegal_err_cleared got=%b want=0", err); end
    total++; if (out_y !== x) begin bad++; $display("[TB] FAIL illegal_next_y got=%h want=%h", out_y, x); end
    take_output();
  endtask

  task automatic test_reset_mid_job();
    vector_t x;
    logic seen;
    for (int i = 0; i < D; i++) x[i] = 8'sd127;
    @(negedge clk);
    in_w = sat_w();
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ctrl got ready=%b valid=%b busy=%b want 0", in_ready, out_valid, busy); end
    total++; if (out_y !== '0 || sat !== '0 || err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_data got y=%h sat=%b err=%b want 0", out_y, sat, err); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_release got=%b want=1", in_ready); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL midrst_no_output got seen=%b want=0", seen); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_w = '0;
    in_x = '0;
    test_reset();
    test_identity();
    test_saturation();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
